// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, default geometry and helpers for the set-associative data cache
package dcache_pkg;

    localparam int DC_ADDR_W = 32;
    localparam int DC_WORD_W = 32;
    localparam int DC_LINE_W = 256;
    localparam int DC_SETS   = 32;
    localparam int DC_WAYS   = 2;
    localparam int DC_OFF_W  = $clog2(DC_LINE_W / 8);
    localparam int DC_IDX_W  = $clog2(DC_SETS);
    localparam int DC_TAG_W  = DC_ADDR_W - DC_IDX_W - DC_OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_REFILL,
        ST_REFILL_WR,
        ST_FL_SCAN,
        ST_FL_WB,
        ST_FL_DONE
    } dc_state_e;

    // Tag field is address-wide so one entry type serves every cache geometry;
    // shorter tags are zero-extended into it.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [DC_ADDR_W-1:0] tag;
    } tag_entry_t;

    // Width of a way number; a direct-mapped cache still carries one bit.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_way_store.sv
// rtl/dcache_way_store.sv - one cache way: valid/dirty bits, tag and line arrays
module dcache_way_store #(
    parameter int SETS   = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx,
    input  logic              we,
    input  logic [LINE_W-1:0] wdata,
    input  logic [TAG_W-1:0]  wtag,
    input  logic              wdirty,
    input  logic              inv_all,
    output logic              rvalid,
    output logic              rdirty,
    output logic [TAG_W-1:0]  rtag,
    output logic [LINE_W-1:0] rdata
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    // State bits: cleared on reset and by a whole-cache invalidate; any write makes the entry valid
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= wdirty;
        end
    end

    // Tag and line storage, never reset
    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_q[idx]  <= wtag;
            data_q[idx] <= wdata;
        end
    end

    assign rvalid = valid_q[idx];
    assign rdirty = dirty_q[idx];
    assign rtag   = tag_q[idx];
    assign rdata  = data_q[idx];

endmodule

// File: rtl/dcache_sa_top.sv
// rtl/dcache_sa_top.sv - N-way write-back, write-allocate data cache controller with LRU and flush
module dcache_sa_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DC_ADDR_W,
    parameter int WORD_W = DC_WORD_W,
    parameter int LINE_W = DC_LINE_W,
    parameter int SETS   = DC_SETS,
    parameter int WAYS   = DC_WAYS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic              flush_i,
    output logic              flush_done_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = way_bits(WAYS);
    localparam int WSEL_W = $clog2(LINE_W / WORD_W);

    dc_state_e state_q, state_d;

    logic              req, hit, flushing, scan_last, sel_dirty, inv_all, w_dirty, touch;
    logic [TAG_W-1:0]  p1_tag, w_tag;
    logic [IDX_W-1:0]  p1_idx, arr_idx, scan_set_q;
    logic [WSEL_W-1:0] p1_wsel;
    logic [WAY_W-1:0]  scan_way_q, hit_way, victim_d, victim_q, sel_way, lru_vic;
    logic [WAYS-1:0]   rvalid, rdirty, hit_vec, way_we;
    logic [TAG_W-1:0]  rtag  [WAYS];
    logic [LINE_W-1:0] rline [WAYS];
    logic [LINE_W-1:0] hit_line, merged_line, w_line;
    tag_entry_t        ent   [WAYS];

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign p1_tag   = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1_idx   = p1_addr_i[OFF_W +: IDX_W];
    assign p1_wsel  = p1_addr_i[2 +: WSEL_W];
    assign flushing = (state_q == ST_FL_SCAN) || (state_q == ST_FL_WB) || (state_q == ST_FL_DONE);
    // The flush walks the arrays with its own counter; everything else indexes by the request
    assign arr_idx  = flushing ? scan_set_q : p1_idx;
    assign sel_way  = flushing ? scan_way_q : victim_q;
    assign sel_dirty = rvalid[sel_way] & rdirty[sel_way];
    assign scan_last = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way_store #(
            .SETS  (SETS),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W),
            .LINE_W(LINE_W)
        ) u_store (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .idx    (arr_idx),
            .we     (way_we[w]),
            .wdata  (w_line),
            .wtag   (w_tag),
            .wdirty (w_dirty),
            .inv_all(inv_all),
            .rvalid (rvalid[w]),
            .rdirty (rdirty[w]),
            .rtag   (rtag[w]),
            .rdata  (rline[w])
        );
    end

    // Tag compare across all ways; at most one way can match
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            ent[w]     = '{valid: rvalid[w], dirty: rdirty[w], tag: DC_ADDR_W'(rtag[w])};
            hit_vec[w] = ent[w].valid && (ent[w].tag == DC_ADDR_W'(p1_tag));
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit        = req & (|hit_vec);
    assign p1_stall_o = (req & ~hit) | (state_q != ST_IDLE);
    assign hit_line   = rline[hit_way];
    assign p1_data_o  = hit_line[p1_wsel*WORD_W +: WORD_W];
    assign touch      = (state_q == ST_IDLE) && hit;

    // Store data merged into the hit line
    always_comb begin
        merged_line = hit_line;
        merged_line[p1_wsel*WORD_W +: WORD_W] = p1_data_i;
    end

    // Victim: lowest-numbered invalid way, otherwise the replacement policy's choice
    always_comb begin
        victim_d = lru_vic;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rvalid[w]) victim_d = WAY_W'(w);
        end
    end

    if (WAYS == 2) begin : g_lru2
        logic [SETS-1:0] lru_q;
        // One bit per set naming the least recently used way
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) lru_q <= '0;
            else if (touch) lru_q[p1_idx] <= ~hit_way[0];
        end
        assign lru_vic = lru_q[p1_idx];
    end else if (WAYS == 4) begin : g_plru4
        logic [2:0] plru_q [SETS];
        logic [2:0] cur;
        // Tree bits: [0] points at the colder half, [1] within ways 0/1, [2] within ways 2/3
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            end else if (touch) begin
                plru_q[p1_idx][0] <= ~hit_way[1];
                if (hit_way[1]) plru_q[p1_idx][2] <= ~hit_way[0];
                else            plru_q[p1_idx][1] <= ~hit_way[0];
            end
        end
        assign cur     = plru_q[p1_idx];
        assign lru_vic = {cur[0], cur[0] ? cur[2] : cur[1]};
    end else begin : g_no_lru
        assign lru_vic = '0;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Registered victim and flush scan counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            victim_q   <= '0;
            scan_set_q <= '0;
            scan_way_q <= '0;
        end else begin
            if (state_q == ST_MISS) victim_q <= victim_d;
            if (state_q == ST_IDLE) begin
                scan_set_q <= '0;
                scan_way_q <= '0;
            end else if (state_q == ST_FL_SCAN && !sel_dirty && !scan_last) begin
                if (scan_way_q == WAY_W'(WAYS - 1)) begin
                    scan_way_q <= '0;
                    scan_set_q <= scan_set_q + 1'b1;
                end else begin
                    scan_way_q <= scan_way_q + 1'b1;
                end
            end
        end
    end

    // FSM next-state logic; a pending request wins over flush
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req && !hit)          state_d = ST_MISS;
                else if (flush_i && !req) state_d = ST_FL_SCAN;
            end
            ST_MISS:      state_d = (rvalid[victim_d] && rdirty[victim_d]) ? ST_WRITEBACK : ST_REFILL;
            ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
            ST_REFILL:    if (mem_ack_i) state_d = ST_REFILL_WR;
            ST_REFILL_WR: state_d = ST_IDLE;
            ST_FL_SCAN: begin
                if (sel_dirty)      state_d = ST_FL_WB;
                else if (scan_last) state_d = ST_FL_DONE;
            end
            ST_FL_WB:     if (mem_ack_i) state_d = ST_FL_SCAN;
            ST_FL_DONE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: memory port and array write strobes
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        flush_done_o = 1'b0;
        mem_addr_o   = {p1_tag, p1_idx, {OFF_W{1'b0}}};
        mem_data_o   = rline[sel_way];
        way_we       = '0;
        w_line       = merged_line;
        w_tag        = p1_tag;
        w_dirty      = 1'b1;
        inv_all      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit && p1_MemWrite_i) way_we[hit_way] = 1'b1;
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rtag[sel_way], p1_idx, {OFF_W{1'b0}}};
            end
            ST_REFILL: begin
                mem_enable_o = 1'b1;
            end
            ST_REFILL_WR: begin
                way_we[victim_q] = 1'b1;
                w_line           = mem_data_i;
                w_dirty          = 1'b0;
            end
            ST_FL_SCAN: begin
                if (!sel_dirty && scan_last) inv_all = 1'b1;
            end
            ST_FL_WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rtag[sel_way], scan_set_q, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    way_we[sel_way] = 1'b1;
                    w_line          = rline[sel_way];
                    w_tag           = rtag[sel_way];
                    w_dirty         = 1'b0;
                end
            end
            ST_FL_DONE: begin
                flush_done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
